// File: rtl/pcie_ob_writeback_if.sv
// Signal bundle between the outbound writeback engine, the Ob RAM / AES side
// and the AXI write controller.
interface pcie_ob_writeback_if;
    logic         ObDataValid;
    logic [7:0]   ObCount;
    logic         ObRdEn;
    logic [7:0]   ObRdAddr;
    logic [127:0] ObRdData;
    logic [63:0]  ObBase;
    logic         WrRqValid;
    logic [63:0]  WrRqAddr;
    logic [127:0] WrRqData;
    logic         WrRqReady;
    logic         WrRqErr;
    logic         ObDone;
    logic         ObErr;
    logic [31:0]  ObPtr;

    // The writeback engine masters the write requests and the Ob RAM reads.
    modport master (
        input  ObDataValid, ObCount, ObRdData, ObBase, WrRqReady, WrRqErr,
        output ObRdEn, ObRdAddr, WrRqValid, WrRqAddr, WrRqData, ObDone, ObErr, ObPtr
    );

    modport slave (
        output ObDataValid, ObCount, ObRdData, ObBase, WrRqReady, WrRqErr,
        input  ObRdEn, ObRdAddr, WrRqValid, WrRqAddr, WrRqData, ObDone, ObErr, ObPtr
    );
endinterface

// File: rtl/pcie_ob_writeback.sv
// Drains an outbound batch from Ob RAM into the host ring one 16-byte entry at a
// time, then publishes the new ring write pointer to the host, with retry on error.
module pcie_ob_writeback #(
    parameter logic [63:0] OB_PTR_ADDR = 64'h20,
    parameter int          RING_DEPTH  = 256,
    parameter int          MAX_RETRY   = 3
) (
    input logic               clk,
    input logic               rst_n,
    pcie_ob_writeback_if.master bus
);
    localparam int          RW       = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [31:0] PTR_MASK = 32'(RING_DEPTH - 1);

    typedef enum logic [3:0] {
        IDLE, RD_RAM, CAP, WR_REQ, WR_WAIT, PTR_REQ, PTR_WAIT, DONE, FAULT
    } state_t;

    state_t         r_state;
    logic [7:0]     r_n;
    logic [63:0]    r_base;
    logic [8:0]     r_i;
    logic [RW-1:0]  r_retry;
    logic           r_rd_en;
    logic [7:0]     r_rd_addr;
    logic           r_wr_valid;
    logic [63:0]    r_wr_addr;
    logic [127:0]   r_wr_data;
    logic           r_done;
    logic           r_err;
    logic [31:0]    r_ptr;

    logic [31:0]    w_ptr_inc;
    logic [8:0]     w_i_inc;
    logic [63:0]    w_entry_addr;
    logic           w_wr_ok;
    logic           w_wr_bad;
    logic           w_retry_left;

    assign w_ptr_inc    = (r_ptr + 32'd1) & PTR_MASK;
    assign w_i_inc      = r_i + 9'd1;
    assign w_entry_addr = r_base + {28'h0, r_ptr, 4'h0};
    assign w_wr_ok      = bus.WrRqReady & ~bus.WrRqErr;
    assign w_wr_bad     = bus.WrRqReady &  bus.WrRqErr;
    assign w_retry_left = r_retry < RW'(MAX_RETRY);

    // NOTE: all state and outputs are flops updated with non-blocking assignments;
    // the async reset clears every output, so nothing is visible until a batch starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_n        <= '0;
            r_base     <= '0;
            r_i        <= '0;
            r_retry    <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ptr      <= '0;
        end else begin
            // NOTE: strobes default low so each one is a single-cycle pulse.
            r_rd_en    <= 1'b0;
            r_wr_valid <= 1'b0;
            r_done     <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.ObDataValid && !r_err) begin
                        r_n     <= bus.ObCount;
                        r_base  <= bus.ObBase;
                        r_i     <= '0;
                        r_retry <= '0;
                        if (bus.ObCount == 8'd0) begin
                            r_state    <= PTR_REQ;
                            r_wr_valid <= 1'b1;
                            r_wr_addr  <= OB_PTR_ADDR;
                            r_wr_data  <= {96'h0, r_ptr};
                        end else begin
                            r_state   <= RD_RAM;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= 8'h0;
                        end
                    end
                end

                RD_RAM: r_state <= CAP;

                CAP: begin
                    r_wr_data  <= bus.ObRdData;
                    r_wr_addr  <= w_entry_addr;
                    r_wr_valid <= 1'b1;
                    r_state    <= WR_REQ;
                end

                WR_REQ: r_state <= WR_WAIT;

                WR_WAIT: begin
                    if (w_wr_ok) begin
                        r_ptr   <= w_ptr_inc;
                        r_i     <= w_i_inc;
                        r_retry <= '0;
                        if (w_i_inc < {1'b0, r_n}) begin
                            r_state   <= RD_RAM;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= w_i_inc[7:0];
                        end else begin
                            // Pointer write must carry the post-increment value.
                            r_state    <= PTR_REQ;
                            r_wr_valid <= 1'b1;
                            r_wr_addr  <= OB_PTR_ADDR;
                            r_wr_data  <= {96'h0, w_ptr_inc};
                        end
                    end else if (w_wr_bad) begin
                        if (w_retry_left) begin
                            r_retry    <= r_retry + 1'b1;
                            r_wr_valid <= 1'b1;
                            r_state    <= WR_REQ;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= FAULT;
                        end
                    end
                end

                PTR_REQ: r_state <= PTR_WAIT;

                PTR_WAIT: begin
                    if (w_wr_ok) begin
                        r_retry <= '0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_wr_bad) begin
                        if (w_retry_left) begin
                            r_retry    <= r_retry + 1'b1;
                            r_wr_valid <= 1'b1;
                            r_state    <= PTR_REQ;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= FAULT;
                        end
                    end
                end

                // Hold here so one ObDataValid assertion yields exactly one batch.
                DONE: if (!bus.ObDataValid) r_state <= IDLE;

                FAULT: begin
                    r_err   <= 1'b1;
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ObRdEn    = r_rd_en;
    assign bus.ObRdAddr  = r_rd_addr;
    assign bus.WrRqValid = r_wr_valid;
    assign bus.WrRqAddr  = r_wr_addr;
    assign bus.WrRqData  = r_wr_data;
    assign bus.ObDone    = r_done;
    assign bus.ObErr     = r_err;
    assign bus.ObPtr     = r_ptr;
endmodule

// File: tb/tb_pcie_ob_writeback.sv
// Directed bench for pcie_ob_writeback: normal batches, ring wrap, retry, fault,
// empty batch and mid-batch reset, with a simple Ob RAM model behind the DUT.
module tb_pcie_ob_writeback;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   valid_cnt = 0;

    logic [127:0] mem [256];

    pcie_ob_writeback_if bus ();

    pcie_ob_writeback #(
        .OB_PTR_ADDR (64'h20),
        .RING_DEPTH  (256),
        .MAX_RETRY   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ob RAM: data valid only in the cycle after the read strobe.
    always @(posedge clk) bus.ObRdData <= bus.ObRdEn ? mem[bus.ObRdAddr] : {4{32'hBAD0_BAD0}};

    always @(negedge clk) begin
        if (bus.ObDone)    done_cnt  = done_cnt + 1;
        if (bus.WrRqValid) valid_cnt = valid_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, output bit seen);
        int n = 0;
        while (!bus.WrRqValid && n < 200) begin
            @(negedge clk);
            n++;
        end
        seen = bus.WrRqValid;
        chk({tag, "_valid_seen"}, 128'(bus.WrRqValid), 128'(1));
    endtask

    // Wait for one write request, check it, and complete it k cycles later.
    task automatic serve(input string tag, input logic [63:0] ea, input logic [127:0] ed,
                         input int k, input bit err, output int vcyc);
        bit seen;
        wait_valid(tag, seen);
        vcyc = cyc;
        if (seen) begin
            chk({tag, "_addr"}, 128'(bus.WrRqAddr), 128'(ea));
            chk({tag, "_data"}, bus.WrRqData, ed);
            repeat (k) @(negedge clk);
            chk({tag, "_pulse"}, 128'(bus.WrRqValid), 128'(0));
            chk({tag, "_hold"}, {bus.WrRqData[63:0], bus.WrRqAddr}, {ed[63:0], ea});
            bus.WrRqReady = 1'b1;
            bus.WrRqErr   = err;
            @(negedge clk);
            bus.WrRqReady = 1'b0;
            bus.WrRqErr   = 1'b0;
        end
    endtask

    task automatic start_batch(input logic [63:0] base, input logic [7:0] count);
        @(negedge clk);
        bus.ObBase      = base;
        bus.ObCount     = count;
        bus.ObDataValid = 1'b1;
    endtask

    // Called right after the pointer write completes.
    task automatic end_batch(input string tag, input int done_before, input logic [31:0] ptr);
        chk({tag, "_done_now"}, 128'(bus.ObDone), 128'(1));
        repeat (4) @(negedge clk);
        chk({tag, "_done_once"}, 128'(done_cnt), 128'(done_before + 1));
        chk({tag, "_ptr"}, 128'(bus.ObPtr), 128'(ptr));
        chk({tag, "_err"}, 128'(bus.ObErr), 128'(0));
        bus.ObDataValid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  vc0, vc1, vtmp, db, vb;
        bit  seen;

        for (int i = 0; i < 256; i++)
            mem[i] = {32'hA000_0000 + 32'(i), 32'h1111_0000 + 32'(i),
                      32'h2222_0000 + 32'(i), 32'h3333_0000 + 32'(i)};

        bus.ObDataValid = 1'b0;
        bus.ObCount     = 8'h0;
        bus.ObBase      = 64'h0;
        bus.WrRqReady   = 1'b0;
        bus.WrRqErr     = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rden",  128'(bus.ObRdEn),    128'(0));
        chk("rst_rdadr", 128'(bus.ObRdAddr),  128'(0));
        chk("rst_valid", 128'(bus.WrRqValid), 128'(0));
        chk("rst_addr",  128'(bus.WrRqAddr),  128'(0));
        chk("rst_data",  bus.WrRqData,        128'(0));
        chk("rst_flags", 128'({bus.ObDone, bus.ObErr}), 128'(0));
        chk("rst_ptr",   128'(bus.ObPtr),     128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two entries at 0x1000, Ready two cycles after each Valid
        db = done_cnt;
        start_batch(64'h1000, 8'd2);
        serve("a_e0", 64'h1000, mem[0], 2, 1'b0, vc0);
        serve("a_e1", 64'h1010, mem[1], 2, 1'b0, vc1);
        chk("a_latency", 128'(vc1 - vc0), 128'(5));
        serve("a_ptr", 64'h20, 128'(2), 2, 1'b0, vtmp);
        end_batch("a", db, 32'd2);

        // Advance the ring to its last entry with a long batch
        db = done_cnt;
        start_batch(64'h0, 8'd253);
        for (int j = 0; j < 253; j++)
            serve("fill", 64'((2 + j) * 16), mem[j], 1, 1'b0, vtmp);
        serve("fill_ptr", 64'h20, 128'(255), 1, 1'b0, vtmp);
        end_batch("fill", db, 32'd255);

        // Wrap from RING_DEPTH-1 to 0
        db = done_cnt;
        start_batch(64'h1_0000_0000, 8'd2);
        serve("w_e0", 64'h1_0000_0FF0, mem[0], 1, 1'b0, vtmp);
        serve("w_e1", 64'h1_0000_0000, mem[1], 1, 1'b0, vtmp);
        serve("w_ptr", 64'h20, 128'(1), 1, 1'b0, vtmp);
        end_batch("w", db, 32'd1);

        // Single error on entry 0, then success on re-issue
        db = done_cnt;
        start_batch(64'h2000, 8'd1);
        serve("r_try0", 64'h2010, mem[0], 1, 1'b1, vtmp);
        serve("r_try1", 64'h2010, mem[0], 3, 1'b0, vtmp);
        serve("r_ptr", 64'h20, 128'(2), 1, 1'b0, vtmp);
        end_batch("r", db, 32'd2);

        // Empty batch: pointer write only, pointer unchanged
        db = done_cnt;
        vb = valid_cnt;
        start_batch(64'h7000, 8'd0);
        serve("z_ptr", 64'h20, 128'(2), 2, 1'b0, vtmp);
        chk("z_one_write", 128'(valid_cnt), 128'(vb + 1));
        end_batch("z", db, 32'd2);

        // Reset while waiting for a write completion
        start_batch(64'h3000, 8'd1);
        wait_valid("x", seen);
        chk("x_addr", 128'(bus.WrRqAddr), 128'(64'h3020));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("x_rst_addr", 128'(bus.WrRqAddr), 128'(0));
        chk("x_rst_data", bus.WrRqData, 128'(0));
        chk("x_rst_ptr",  128'(bus.ObPtr), 128'(0));
        chk("x_rst_misc", 128'({bus.WrRqValid, bus.ObRdEn, bus.ObDone, bus.ObErr}), 128'(0));
        bus.ObDataValid = 1'b0;
        vb = valid_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        bus.WrRqReady = 1'b1;
        @(negedge clk);
        bus.WrRqReady = 1'b0;
        repeat (8) @(negedge clk);
        chk("x_no_valid", 128'(valid_cnt), 128'(vb));
        chk("x_ptr_idle", 128'(bus.ObPtr), 128'(0));

        // Four consecutive errors exhaust the retry budget
        db = done_cnt;
        vb = valid_cnt;
        start_batch(64'h5000, 8'd1);
        for (int t = 0; t < 4; t++)
            serve("f_try", 64'h5000, mem[0], 1, 1'b1, vtmp);
        repeat (5) @(negedge clk);
        chk("f_err",      128'(bus.ObErr), 128'(1));
        chk("f_attempts", 128'(valid_cnt), 128'(vb + 4));
        chk("f_no_done",  128'(done_cnt), 128'(db));
        chk("f_ptr",      128'(bus.ObPtr), 128'(0));
        bus.ObDataValid = 1'b0;
        repeat (2) @(negedge clk);
        bus.ObDataValid = 1'b1;
        repeat (20) @(negedge clk);
        chk("f_ignored",  128'(valid_cnt), 128'(vb + 4));
        chk("f_sticky",   128'(bus.ObErr), 128'(1));
        chk("f_no_rd",    128'(bus.ObRdEn), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
